// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable N-bit pattern, overlap control and a saturating match counter.
// Latency: y pulses one cycle after the sampling edge that completes a match. No backpressure (en gates sampling).
module seq_detect_param #(
  parameter int               N       = 4,
  parameter int               CNT_W   = 8,
  parameter logic [N-1:0]     PAT_RST = 4'b1011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dt,
  input  logic                     en,
  input  logic                     overlap,
  input  logic                     pat_load,
  input  logic [N-1:0]             pat_in,
  input  logic                     cnt_clr,
  output logic                     y,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(N+1)-1:0]   curr_state
);

  localparam int             FW        = $clog2(N + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [FW-1:0]  FILL_ONE  = FW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N-1:0]     pat_q,  pat_d;
  logic [N-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             y_q,    y_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [N-1:0]     hist_shift;
  logic [FW-1:0]    fill_inc;
  logic             match;

  // Match decision is made against the pattern held before this edge, so a
  // same-edge pat_load only affects later samples.
  always_comb begin
    hist_shift = {hist_q[N-2:0], dt};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_ONE;
    match      = en && (hist_shift == pat_q) && (fill_inc == FILL_FULL);
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = match;
    cnt_d  = cnt_q;

    if (pat_load) begin
      pat_d = pat_in;
    end

    if (en) begin
      hist_d = hist_shift;
      if (match) begin
        // Non-overlapping mode restarts collection from an empty history.
        fill_d = overlap ? FILL_FULL : '0;
      end else begin
        fill_d = fill_inc;
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y          = y_q;
  assign match_cnt  = cnt_q;
  assign curr_state = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: stimulus pushes hand-computed (y, match_cnt, curr_state)
// per sampling edge into a queue; a negedge monitor pops and compares.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dt, en, overlap, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic       y;
  logic [1:0] match_cnt;
  logic [2:0] curr_state;

  int errors = 0;
  int checks = 0;
  int step_id = 0;

  typedef struct packed {
    logic        y;
    logic [7:0]  cnt;
    logic [7:0]  fill;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];

  seq_detect_param #(.N(4), .CNT_W(2), .PAT_RST(4'b1011)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dt         (dt),
    .en         (en),
    .overlap    (overlap),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .cnt_clr    (cnt_clr),
    .y          (y),
    .match_cnt  (match_cnt),
    .curr_state (curr_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("y",          int'(e.id), int'(y),          int'(e.y));
      chk("match_cnt",  int'(e.id), int'(match_cnt),  int'(e.cnt));
      chk("curr_state", int'(e.id), int'(curr_state), int'(e.fill));
    end
  end

  // One sampling edge; expected outputs are those visible after that edge.
  task automatic step(input logic d, input logic e, input logic ey, input int ec, input int ef);
    dt = d;
    en = e;
    @(posedge clk);
    exp_q.push_back('{y: ey, cnt: 8'(ec), fill: 8'(ef), id: 16'(step_id)});
    step_id++;
    #1;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    @(negedge clk);
  endtask

  // Reset pulse entirely inside the clock-low phase; outputs must clear at once.
  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y",     step_id, int'(y),          0);
    chk("rst_cnt",   step_id, int'(match_cnt),  0);
    chk("rst_state", step_id, int'(curr_state), 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dt = 1'b0; en = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
    #2;
    chk("init_y",     0, int'(y),          0);
    chk("init_cnt",   0, int'(match_cnt),  0);
    chk("init_state", 0, int'(curr_state), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Overlapping stream 1011011: matches after bits 4 and 7.
    overlap = 1'b1;
    step(1, 1, 0, 0, 1); step(0, 1, 0, 0, 2); step(1, 1, 0, 0, 3); step(1, 1, 1, 1, 4);
    step(0, 1, 0, 1, 4); step(1, 1, 0, 1, 4); step(1, 1, 1, 2, 4);
    cnt_clr = 1'b1;
    step(0, 0, 0, 0, 4);

    // Same stream, non-overlapping: one match, fill restarts.
    rst_pulse();
    overlap = 1'b0;
    step(1, 1, 0, 0, 1); step(0, 1, 0, 0, 2); step(1, 1, 0, 0, 3); step(1, 1, 1, 1, 0);
    step(0, 1, 0, 1, 1); step(1, 1, 0, 1, 2); step(1, 1, 0, 1, 3);

    // en=0 gaps freeze history and fill while dt toggles.
    rst_pulse();
    overlap = 1'b1;
    step(1, 1, 0, 0, 1); step(0, 1, 0, 0, 2);
    step(1, 0, 0, 0, 2); step(0, 0, 0, 0, 2); step(1, 0, 0, 0, 2);
    step(1, 1, 0, 0, 3); step(1, 1, 1, 1, 4);
    step(1, 0, 0, 1, 4);

    // Load 0110 on a sampling edge where history becomes 0110: old pattern decides, no match.
    pat_load = 1'b1; pat_in = 4'b0110;
    step(0, 1, 0, 1, 4);
    step(0, 1, 0, 1, 4); step(1, 1, 0, 1, 4); step(1, 1, 0, 1, 4); step(0, 1, 1, 2, 4);
    step(1, 1, 0, 2, 4); step(1, 1, 0, 2, 4);

    // Clear coinciding with a match, then five overlapping matches saturate at 3.
    cnt_clr = 1'b1;
    step(0, 1, 1, 0, 4);
    for (int g = 1; g <= 5; g++) begin
      step(1, 1, 0, (g > 3) ? 3 : g - 1, 4);
      step(1, 1, 0, (g > 3) ? 3 : g - 1, 4);
      step(0, 1, 1, (g > 3) ? 3 : g, 4);
    end

    // Reset after 1,0,1: collected bits discarded, pattern back to 1011.
    step(1, 1, 0, 3, 4); step(0, 1, 0, 3, 4); step(1, 1, 0, 3, 4);
    rst_pulse();
    step(1, 1, 0, 0, 1); step(0, 1, 0, 0, 2); step(1, 1, 0, 0, 3); step(1, 1, 1, 1, 4);
    cnt_clr = 1'b1;
    step(0, 0, 0, 0, 4);

    repeat (2) @(negedge clk);
    chk("queue_drained", step_id, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter N, default 4, pattern length in bits (N >= 2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have parameter [N-1:0] PAT_RST, default 4'b1011, pattern register value after reset.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port dt  input  1  serial data bit, sampled at rising clk when en=1.
REQ-007 SHALL have port en  input  1  sample enable; en=0 freezes the detector.
REQ-008 SHALL have port overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 SHALL have port pat_load  input  1  strobe to latch pat_in into the pattern register.
REQ-010 SHALL have port pat_in  input  N  new pattern; pat_in[N-1] is the first bit expected, pat_in[0] the last.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 SHALL have port y  output  1  registered match pulse.
REQ-013 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-014 SHALL have port curr_state  output  clog2(N+1)  number of valid history bits, 0..N.

Function
REQ-015 SHALL keep an N-bit history hist; on each edge with en=1, hist <= {hist[N-2:0], dt}, so the newest bit is hist[0].
REQ-016 SHALL keep a fill count curr_state; on an en=1 edge it increments, saturating at N.
REQ-017 SHALL declare a match at an en=1 edge when the post-shift history equals the pattern register and the post-increment fill equals N.
REQ-018 SHALL drive y=1 for exactly the one cycle after a matching edge, and y=0 otherwise (1-cycle latency from the last pattern bit's sampling edge).
REQ-019 SHALL, on a match with overlap=1, keep hist and set fill to N, so the next bit can complete another match.
REQ-020 SHALL, on a match with overlap=0, set fill to 0 (hist contents don't care), so the next match needs N fresh bits.
REQ-021 SHALL, on an en=0 edge, hold hist, fill, and match_cnt, and drive y=0 in the following cycle.
REQ-022 SHALL, on a pat_load edge, load pat_in into the pattern register regardless of en; hist and fill are unchanged.
REQ-023 SHALL use the pre-load pattern for the match decision when pat_load and a sample occur on the same edge.
REQ-024 SHALL increment match_cnt by 1 on each match, saturating at 2^CNT_W-1 (no wrap).
REQ-025 SHALL clear match_cnt to 0 on a cnt_clr edge; if cnt_clr and a match occur on the same edge, match_cnt becomes 0 and y still pulses.
REQ-026 SHALL sample overlap at the matching edge; a change of overlap between matches takes effect from the next match.

Reset
REQ-027 SHALL, while rst_n=0, immediately force hist=0, curr_state=0, y=0, match_cnt=0, and pattern=PAT_RST, independent of clk.
REQ-028 SHALL, after rst_n deasserts mid-stream, discard all previously collected bits; the first match needs N new samples.
REQ-029 SHALL NOT act on any input during the edge on which rst_n deasserts if rst_n is still low at that edge.

Verification
REQ-030 SHALL cover: N=4, pattern 1011, overlap=1, en=1, dt=1,0,1,1,0,1,1 -> y=1 after bits 4 and 7, match_cnt=2.
REQ-031 SHALL cover: same stream with overlap=0 -> y=1 only after bit 4, match_cnt=1, curr_state=3 after bit 7.
REQ-032 SHALL cover: dt=1,0 then en=0 for 3 cycles with dt toggling, then en=1 with dt=1,1 -> y=1 once, curr_state held at 2 while en=0.
REQ-033 SHALL cover: pat_load with pat_in=0110 mid-stream, then dt=0,1,1,0 -> y=1 after the final 0; the old pattern 1011 no longer matches.
REQ-034 SHALL cover: CNT_W=2, five matches -> match_cnt saturates at 3; cnt_clr then gives 0.
REQ-035 SHALL cover: rst_n pulsed low between clk edges after dt=1,0,1 -> y, match_cnt, and curr_state are 0 at once; a following 1 gives no match.
